// File: rtl/syscall_unit.sv
// SYSCALL service engine: print int/char, exit, and (with SYSCALL_PRINT_STR_EN) print string.
// Stalls the pipeline, streams ASCII bytes over valid/ready, and pulses done on completion.
module syscall_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_req,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        done,
  output logic        halt,
  output logic        bad_call,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [3:0] {
    StIdle, StConv, StSign, StDigit, StChar, StStrRd, StStrOut, StDone, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic [7:0]  od_q, od_d;
  logic        bad_q, bad_d;
  logic        hs;

  logic [39:0] bcd_adj, bcd_shift, bcd_norm;
  logic [3:0]  lead, sig;
  logic        found;

  // One double-dabble step, plus left-justification of the final result so the
  // most significant nonzero digit sits in the top nibble.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[38:0], bin_q[31]};
    lead  = 4'd0;
    found = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (!found) begin
        if (bcd_shift[4*i +: 4] != 4'd0) found = 1'b1;
        else lead = lead + 4'd1;
      end
    end
    if (lead == 4'd10) lead = 4'd9;
    sig      = 4'd10 - lead;
    bcd_norm = bcd_shift << {lead, 2'b00};
  end

`ifdef SYSCALL_PRINT_STR_EN
  logic [31:0] ptr_q, ptr_d;
`else
  logic unused_mem;
  assign unused_mem = ^{mem_ack, mem_rdata};
`endif

  assign hs = ov_q && out_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    bad_d   = bad_q;
`ifdef SYSCALL_PRINT_STR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (syscall_req) begin
          bad_d = 1'b0;
          case (v0)
            32'd1: begin
              bin_d = a0[31] ? (~a0 + 32'd1) : a0;
              bcd_d = 40'd0;
              cnt_d = 6'd0;
              if (a0[31]) begin
                state_d = StSign;
                ov_d    = 1'b1;
                od_d    = 8'h2d;
              end else begin
                state_d = StConv;
              end
            end
            32'd11: begin
              state_d = StChar;
              ov_d    = 1'b1;
              od_d    = a0[7:0];
            end
            32'd10: state_d = StHalt;
`ifdef SYSCALL_PRINT_STR_EN
            32'd4: begin
              state_d = StStrRd;
              ptr_d   = a0;
            end
`endif
            default: begin
              state_d = StDone;
              bad_d   = 1'b1;
            end
          endcase
        end
      end
      StSign: begin
        if (hs) begin
          ov_d    = 1'b0;
          state_d = StConv;
        end
      end
      StConv: begin
        bin_d = {bin_q[30:0], 1'b0};
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          bcd_d   = bcd_norm;
          cnt_d   = {2'b00, sig};
          state_d = StDigit;
          ov_d    = 1'b1;
          od_d    = 8'h30 + {4'h0, bcd_norm[39:36]};
        end
      end
      StDigit: begin
        if (hs) begin
          if (cnt_q == 6'd1) begin
            ov_d    = 1'b0;
            state_d = StDone;
          end else begin
            bcd_d = {bcd_q[35:0], 4'h0};
            cnt_d = cnt_q - 6'd1;
            od_d  = 8'h30 + {4'h0, bcd_q[35:32]};
          end
        end
      end
      StChar: begin
        if (hs) begin
          ov_d    = 1'b0;
          state_d = StDone;
        end
      end
`ifdef SYSCALL_PRINT_STR_EN
      StStrRd: begin
        if (mem_ack) begin
          if (mem_rdata == 8'h00) begin
            state_d = StDone;
          end else begin
            state_d = StStrOut;
            ov_d    = 1'b1;
            od_d    = mem_rdata;
            ptr_d   = ptr_q + 32'd1;
          end
        end
      end
      StStrOut: begin
        if (hs) begin
          ov_d    = 1'b0;
          state_d = StStrRd;
        end
      end
`endif
      StDone:  state_d = StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= 32'd0;
      bcd_q   <= 40'd0;
      cnt_q   <= 6'd0;
      ov_q    <= 1'b0;
      od_q    <= 8'd0;
      bad_q   <= 1'b0;
`ifdef SYSCALL_PRINT_STR_EN
      ptr_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      bad_q   <= bad_d;
`ifdef SYSCALL_PRINT_STR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Freeze the pipeline in the request cycle itself, and release it during DONE.
  assign stall     = (state_q != StIdle && state_q != StDone) ||
                     (state_q == StIdle && syscall_req);
  assign done      = (state_q == StDone);
  assign bad_call  = (state_q == StDone) && bad_q;
  assign halt      = (state_q == StHalt);
  assign out_valid = ov_q;
  assign out_data  = od_q;
`ifdef SYSCALL_PRINT_STR_EN
  assign mem_rd    = (state_q == StStrRd);
  assign mem_addr  = (state_q == StStrRd) ? ptr_q : 32'd0;
`else
  assign mem_rd    = 1'b0;
  assign mem_addr  = 32'd0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table, hand sequences for halt/reset/string,
// and randomized calls checked against a string-level reference model.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset, syscall_req, out_ready, mem_ack;
  logic [31:0] v0, a0, mem_addr;
  logic [7:0]  mem_rdata, out_data;
  logic        stall, done, halt, bad_call, out_valid, mem_rd;

  syscall_unit dut (
    .clk        (clk),
    .reset      (reset),
    .syscall_req(syscall_req),
    .v0         (v0),
    .a0         (a0),
    .stall      (stall),
    .done       (done),
    .halt       (halt),
    .bad_call   (bad_call),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_int(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got [%s], expected [%s]", name, act, exp);
    end
  endtask

  function automatic string hexs(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02x ", s[i])};
    return r;
  endfunction

  // Byte memory with configurable ack latency
  logic [7:0]  mem [logic [31:0]];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] rd_addrs[$];

  always @(negedge clk) begin
    if (mem_rd && !reset) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
        rd_addrs.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Results of the last call
  string got_s;
  int    done_at, bad_at, halt_at;
  bit    stall_ok, stream_ok;

  function automatic logic pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c[0];
    return 1'($urandom_range(0, 1));
  endfunction

  // Issue a call at the current cycle (entered just after a rising edge), hold the request
  // until done, and record everything seen relative to the request cycle.
  task automatic do_call(input logic [31:0] v, input logic [31:0] a, input int rmode,
                         input int budget);
    logic pv, pr;
    logic [7:0] pd;
    got_s = ""; done_at = -1; bad_at = -1; halt_at = -1; stall_ok = 1; stream_ok = 1;
    pv = 0; pr = 0; pd = 0;
    v0 = v; a0 = a; syscall_req = 1'b1; out_ready = pick_ready(rmode, 0);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (stall !== (done ? 1'b0 : 1'b1)) stall_ok = 0;
      if (pv && !pr && (!out_valid || out_data !== pd)) stream_ok = 0;
      pv = out_valid; pr = out_ready; pd = out_data;
      if (out_valid && out_ready) got_s = {got_s, $sformatf("%02x ", out_data)};
      if (bad_call) bad_at = c;
      if (halt && halt_at < 0) halt_at = c;
      if (done) done_at = c;
      @(posedge clk); #1;
      out_ready = pick_ready(rmode, c + 1);
      if (done_at >= 0) break;
    end
    syscall_req = 1'b0;
    out_ready = 1'b1;
  endtask

  // Reference model: expected byte string and done latency (ready held high)
  task automatic model(input logic [31:0] v, input logic [31:0] a, output string s,
                       output int dl, output int badat);
    s = ""; dl = 1; badat = -1;
    if (v == 32'd1) begin
      s  = $sformatf("%0d", $signed(a));
      dl = 33 + s.len();
    end else if (v == 32'd11) begin
      s  = $sformatf("%c", a[7:0]);
      dl = 2;
    end else if (v == 32'd10) begin
      dl = -1;
`ifdef SYSCALL_PRINT_STR_EN
    end else if (v == 32'd4) begin
      logic [31:0] p;
      int n;
      p = a; n = 0;
      while (mem.exists(p) && mem[p] != 8'h00) begin
        s = {s, $sformatf("%c", mem[p])};
        p = p + 32'd1;
        n++;
      end
      dl = 1 + (n + 1) * (mem_lat + 1) + n;
`endif
    end else begin
      badat = 1;
    end
  endtask

  typedef struct {
    logic [31:0] v;
    logic [31:0] a;
    int          rmode;
    string       exp;
    int          exp_done;
    int          exp_bad;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    string es;
    int    edl, ebad, nvalid;

    vecs[0]  = '{32'd1,  32'd0,          0, "0",           34, -1};
    vecs[1]  = '{32'd1,  32'h8000_0000,  0, "-2147483648", 44, -1};
    vecs[2]  = '{32'd1,  32'h8000_0000,  1, "-2147483648", -1, -1};
    vecs[3]  = '{32'd11, 32'h41,         0, "A",            2, -1};
    vecs[4]  = '{32'd7,  32'h41,         0, "",             1,  1};
    vecs[5]  = '{32'd1,  32'd12345,      0, "12345",       38, -1};
    vecs[6]  = '{32'd1,  32'hffff_ffff,  2, "-1",          -1, -1};
    vecs[7]  = '{32'd1,  32'h7fff_ffff,  0, "2147483647",  43, -1};
    vecs[8]  = '{32'd11, 32'h17a,        1, "z",           -1, -1};
    vecs[9]  = '{32'd0,  32'd0,          0, "",             1,  1};
    vecs[10] = '{32'd1,  32'd1000000000, 0, "1000000000",  43, -1};
`ifdef SYSCALL_PRINT_STR_EN
    vecs[11] = '{32'd4,  32'h200,        0, "",             2, -1};
`else
    vecs[11] = '{32'd4,  32'h200,        0, "",             1,  1};
`endif

    reset = 1'b1; syscall_req = 1'b0; v0 = 0; a0 = 0; out_ready = 1'b1;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_stall", stall, 0);
    check_int("rst_done", done, 0);
    check_int("rst_halt", halt, 0);
    check_int("rst_bad_call", bad_call, 0);
    check_int("rst_out_valid", out_valid, 0);
    check_int("rst_out_data", out_data, 0);
    check_int("rst_mem_rd", mem_rd, 0);
    check_int("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      mem.delete();
      do_call(vecs[i].v, vecs[i].a, vecs[i].rmode, 200);
      check_str($sformatf("vec%0d_bytes", i), got_s, hexs(vecs[i].exp));
      if (vecs[i].exp_done >= 0) check_int($sformatf("vec%0d_done", i), done_at, vecs[i].exp_done);
      else check_int($sformatf("vec%0d_done_seen", i), done_at >= 0, 1);
      check_int($sformatf("vec%0d_bad", i), bad_at, vecs[i].exp_bad);
      check_int($sformatf("vec%0d_stall", i), stall_ok, 1);
      check_int($sformatf("vec%0d_stream", i), stream_ok, 1);
    end

    // String "Hi" at 0x100 with a 2-cycle ack latency
    mem.delete();
    mem[32'h100] = 8'h48; mem[32'h101] = 8'h69; mem[32'h102] = 8'h00;
    mem_lat = 2;
    rd_addrs.delete();
    do_call(32'd4, 32'h100, 0, 200);
`ifdef SYSCALL_PRINT_STR_EN
    check_str("str_bytes", got_s, hexs("Hi"));
    check_int("str_done", done_at, 12);
    check_int("str_nreads", rd_addrs.size(), 3);
    if (rd_addrs.size() == 3) begin
      check_int("str_addr0", rd_addrs[0], 32'h100);
      check_int("str_addr1", rd_addrs[1], 32'h101);
      check_int("str_addr2", rd_addrs[2], 32'h102);
    end
`else
    check_str("str_bytes", got_s, "");
    check_int("str_bad", bad_at, 1);
    check_int("str_nreads", rd_addrs.size(), 0);
`endif
    mem_lat = 0;

    // Exit: sticky halt, stall held, later requests ignored, reset recovers
    do_call(32'd10, 32'd0, 0, 50);
    check_int("halt_rise", halt_at, 1);
    check_int("halt_no_done", done_at, -1);
    check_int("halt_stall", stall_ok, 1);
    v0 = 32'd11; a0 = 32'h41; syscall_req = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid || done || !halt) nvalid++;
      @(posedge clk); #1;
    end
    check_int("halt_ignores_req", nvalid, 0);
    syscall_req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_int("halt_reset_halt", halt, 0);
    check_int("halt_reset_stall", stall, 0);
    @(posedge clk); #1;

    // Reset in the middle of a conversion
    v0 = 32'd1; a0 = 32'd12345; syscall_req = 1'b1;
    nvalid = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
      @(posedge clk); #1;
      if (c == 9) begin
        reset = 1'b1; syscall_req = 1'b0;
      end
    end
    reset = 1'b0;
    @(negedge clk);
    check_int("midrst_no_bytes", nvalid, 0);
    check_int("midrst_stall", stall, 0);
    check_int("midrst_valid", out_valid, 0);
    @(posedge clk); #1;
    do_call(32'd1, 32'd7, 0, 200);
    check_str("midrst_next_bytes", got_s, hexs("7"));
    check_int("midrst_next_done", done_at, 34);

    // Randomized calls against the reference model
    for (int it = 0; it < 40; it++) begin
      logic [31:0] v, a;
      int kind, rmode;
      kind  = $urandom_range(0, 3);
      rmode = $urandom_range(0, 2);
      mem.delete();
      mem_lat = $urandom_range(0, 3);
      case (kind)
        0: begin
          v = 32'd1;
          a = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 999));
        end
        1: begin
          v = 32'd11;
          a = {$urandom_range(0, 16777215), 8'($urandom_range(32, 126))};
        end
        2: begin
          v = $urandom();
          if (v == 32'd1 || v == 32'd4 || v == 32'd10 || v == 32'd11) v = 32'd99;
          a = $urandom();
        end
        default: begin
          int n;
          v = 32'd4;
          a = $urandom();
          n = $urandom_range(0, 4);
          for (int k = 0; k < n; k++) mem[a + 32'(k)] = 8'($urandom_range(97, 122));
          mem[a + 32'(n)] = 8'h00;
        end
      endcase
      model(v, a, es, edl, ebad);
      do_call(v, a, rmode, 300);
      check_str($sformatf("rnd%0d_bytes", it), got_s, hexs(es));
      if (rmode == 0) check_int($sformatf("rnd%0d_done", it), done_at, edl);
      else check_int($sformatf("rnd%0d_done_seen", it), done_at >= 0, 1);
      check_int($sformatf("rnd%0d_bad", it), bad_at, ebad);
      check_int($sformatf("rnd%0d_stall", it), stall_ok, 1);
      check_int($sformatf("rnd%0d_stream", it), stream_ok, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
